// File: rtl/psram_user_emu.sv
// Block-RAM stand-in for the PSRAM controller user channel, with calibration delay and command spacing.
// Define PSRAM_EMU_ERRCHK_EN to enable the sticky cmd_err protocol checker; otherwise cmd_err is tied low.
module psram_user_emu #(
  parameter int AW          = 14,
  parameter int BURST       = 4,
  parameter int READ_LAT    = 6,   // must be >= 3
  parameter int TRC         = 4,
  parameter int INIT_CYCLES = 64
) (
  input  logic        clk_out,
  input  logic        rst_n,
  output logic        init_calib,
  input  logic        cmd,
  input  logic        cmd_en,
  input  logic [20:0] addr,
  input  logic [31:0] wr_data,
  input  logic [3:0]  data_mask,
  output logic [31:0] rd_data,
  output logic        rd_data_valid,
  output logic        busy,
  output logic        cmd_err
);

  localparam int IW    = AW - 1;
  localparam int DEPTH = 1 << IW;
  localparam int ICW   = $clog2(INIT_CYCLES + 1);
  localparam int CW    = $clog2(READ_LAT + TRC + 2);
  localparam int BCW   = $clog2(BURST + 1);

  typedef enum logic [2:0] {INIT, IDLE, RD_WAIT, RD_BEAT, WR_BEAT, GAP} state_t;

  state_t         state;
  logic [ICW-1:0] init_cnt;
  logic [CW-1:0]  cnt;
  logic [BCW-1:0] beat_cnt;
  logic [AW-1:0]  beat_addr;

  logic [15:0] mem_even [DEPTH];
  logic [15:0] mem_odd  [DEPTH];

  logic          ram_we;
  logic [AW-1:0] cur_addr;
  logic          swap;
  logic [IW-1:0] idx_hi, idx_even, idx_odd;
  logic [15:0]   even_wdata, odd_wdata;
  logic [1:0]    even_be, odd_be;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^addr[20:AW];

  // Beat 0 of a write uses the live address in the accept cycle; later beats use the stepped copy.
  assign cur_addr = (state == IDLE) ? addr[AW-1:0] : beat_addr;
  assign ram_we   = ((state == IDLE) && cmd_en && cmd) || (state == WR_BEAT);

  // An odd start puts the high halfword in the odd bank and the low one in the next even row.
  assign swap       = cur_addr[0];
  assign idx_hi     = cur_addr[AW-1:1];
  assign idx_even   = swap ? idx_hi + IW'(1) : idx_hi;
  assign idx_odd    = idx_hi;
  assign even_wdata = swap ? wr_data[15:0]  : wr_data[31:16];
  assign odd_wdata  = swap ? wr_data[31:16] : wr_data[15:0];
  assign even_be    = ram_we ? ~(swap ? data_mask[1:0] : data_mask[3:2]) : 2'b00;
  assign odd_be     = ram_we ? ~(swap ? data_mask[3:2] : data_mask[1:0]) : 2'b00;

  always_ff @(posedge clk_out) begin
    if (even_be[1]) mem_even[idx_even][15:8] <= even_wdata[15:8];
    if (even_be[0]) mem_even[idx_even][7:0]  <= even_wdata[7:0];
    if (odd_be[1])  mem_odd[idx_odd][15:8]   <= odd_wdata[15:8];
    if (odd_be[0])  mem_odd[idx_odd][7:0]    <= odd_wdata[7:0];
  end

  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      state         <= INIT;
      init_cnt      <= '0;
      init_calib    <= 1'b0;
      busy          <= 1'b0;
      rd_data       <= '0;
      rd_data_valid <= 1'b0;
      cnt           <= '0;
      beat_cnt      <= '0;
      beat_addr     <= '0;
    end else begin
      rd_data_valid <= 1'b0;
      case (state)
        INIT: begin
          if (init_cnt == ICW'(INIT_CYCLES - 1)) begin
            init_calib <= 1'b1;
            state      <= IDLE;
          end else begin
            init_cnt <= init_cnt + ICW'(1);
          end
        end
        IDLE: begin
          if (cmd_en) begin
            busy <= 1'b1;
            if (cmd) begin
              beat_addr <= addr[AW-1:0] + AW'(2);
              beat_cnt  <= BCW'(1);
              cnt       <= CW'(TRC - 1);
              state     <= (BURST > 1) ? WR_BEAT : GAP;
            end else begin
              beat_addr <= addr[AW-1:0];
              beat_cnt  <= '0;
              cnt       <= CW'(READ_LAT - 3);
              state     <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          if (cnt == '0) state <= RD_BEAT;
          else           cnt   <= cnt - CW'(1);
        end
        RD_BEAT: begin
          rd_data       <= swap ? {mem_odd[idx_odd], mem_even[idx_even]}
                                : {mem_even[idx_even], mem_odd[idx_odd]};
          rd_data_valid <= 1'b1;
          beat_addr     <= beat_addr + AW'(2);
          // One extra gap cycle covers the registered output of the last beat.
          if (beat_cnt == BCW'(BURST - 1)) begin
            cnt   <= CW'(TRC);
            state <= GAP;
          end else begin
            beat_cnt <= beat_cnt + BCW'(1);
          end
        end
        WR_BEAT: begin
          beat_addr <= beat_addr + AW'(2);
          if (beat_cnt == BCW'(BURST - 1)) state    <= GAP;
          else                             beat_cnt <= beat_cnt + BCW'(1);
        end
        GAP: begin
          if (cnt == '0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= INIT;
      endcase
    end
  end

`ifdef PSRAM_EMU_ERRCHK_EN
  logic cmd_en_q;

  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      cmd_err  <= 1'b0;
      cmd_en_q <= 1'b0;
    end else begin
      cmd_en_q <= cmd_en;
      if (cmd_en && (busy || !init_calib || cmd_en_q)) cmd_err <= 1'b1;
    end
  end
`else
  assign cmd_err = 1'b0;
`endif

endmodule

// File: tb/tb_psram_user_emu.sv
// Directed bench for psram_user_emu: a halfword memory model feeds a queue of expected read beats
// that a negedge monitor checks; timing points are checked inline by the stimulus.
module tb_psram_user_emu;

  localparam int AW = 14;
`ifdef PSRAM_EMU_ERRCHK_EN
  localparam logic ERRCHK = 1'b1;
`else
  localparam logic ERRCHK = 1'b0;
`endif

  logic        clk_out = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd = 1'b0;
  logic        cmd_en = 1'b0;
  logic [20:0] addr = '0;
  logic [31:0] wr_data = '0;
  logic [3:0]  data_mask = 4'hF;
  logic        init_calib, rd_data_valid, busy, cmd_err;
  logic [31:0] rd_data;

  int n_checks = 0;
  int n_fails  = 0;

  logic [15:0] model [0:(1<<AW)-1];
  logic [31:0] exp_q [$];

  psram_user_emu dut (
    .clk_out(clk_out), .rst_n(rst_n), .init_calib(init_calib),
    .cmd(cmd), .cmd_en(cmd_en), .addr(addr), .wr_data(wr_data), .data_mask(data_mask),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid), .busy(busy), .cmd_err(cmd_err)
  );

  always #5 clk_out = ~clk_out;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk_out);
  endtask

  function automatic void model_write(input logic [20:0] a, input int k,
                                      input logic [31:0] d, input logic [3:0] m);
    logic [AW-1:0] h0, h1;
    h0 = a[AW-1:0] + AW'(2 * k);
    h1 = h0 + AW'(1);
    if (!m[3]) model[h0][15:8] = d[31:24];
    if (!m[2]) model[h0][7:0]  = d[23:16];
    if (!m[1]) model[h1][15:8] = d[15:8];
    if (!m[0]) model[h1][7:0]  = d[7:0];
  endfunction

  function automatic logic [31:0] model_read(input logic [20:0] a, input int k);
    logic [AW-1:0] h0, h1;
    h0 = a[AW-1:0] + AW'(2 * k);
    h1 = h0 + AW'(1);
    return {model[h0], model[h1]};
  endfunction

  // Every valid beat must match the oldest outstanding expectation.
  always @(negedge clk_out) begin
    if (rd_data_valid === 1'b1) begin
      if (exp_q.size() == 0) check_output("unexpected_beat", 32'(rd_data_valid), 32'd0);
      else                   check_output("rd_beat", rd_data, exp_q.pop_front());
    end
  end

  // Starts at a negedge, returns at the negedge where the next command may be driven.
  task automatic apply_write(input logic [20:0] a, input logic [31:0] d [4], input logic [3:0] m [4]);
    for (int k = 0; k < 4; k++) begin
      if (k == 0) begin
        cmd_en = 1'b1;
        cmd    = 1'b1;
        addr   = a;
      end else begin
        cmd_en = 1'b0;
      end
      wr_data   = d[k];
      data_mask = m[k];
      model_write(a, k, d[k], m[k]);
      tick();
    end
    cmd_en    = 1'b0;
    wr_data   = '0;
    data_mask = 4'hF;
    tick(3);
    check_output("wr_busy_last_gap", 32'(busy), 32'd1);
    tick();
    check_output("wr_busy_released", 32'(busy), 32'd0);
  endtask

  task automatic apply_read(input logic [20:0] a, input bit poke);
    logic [31:0] last;
    last = '0;
    for (int k = 0; k < 4; k++) begin
      last = model_read(a, k);
      exp_q.push_back(last);
    end
    cmd_en = 1'b1;
    cmd    = 1'b0;
    addr   = a;
    tick();
    cmd_en = 1'b0;
    check_output("rd_busy_start", 32'(busy), 32'd1);
    for (int j = 2; j <= 14; j++) begin
      tick();
      if (poke && j == 5) cmd_en = 1'b1;
      if (poke && j == 6) cmd_en = 1'b0;
      if (poke && j == 7) check_output("err_busy_cmd", 32'(cmd_err), 32'(ERRCHK));
      if (j == 5)  check_output("rd_valid_before", 32'(rd_data_valid), 32'd0);
      if (j == 6)  check_output("rd_valid_first", 32'(rd_data_valid), 32'd1);
      if (j == 9)  check_output("rd_valid_last", 32'(rd_data_valid), 32'd1);
      if (j == 10) check_output("rd_valid_after", 32'(rd_data_valid), 32'd0);
      if (j == 12) check_output("rd_data_hold", rd_data, last);
      if (j == 13) check_output("rd_busy_last_gap", 32'(busy), 32'd1);
      if (j == 14) check_output("rd_busy_released", 32'(busy), 32'd0);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_init_calib"}, 32'(init_calib), 32'd0);
    check_output({tag, "_rd_data"}, rd_data, 32'd0);
    check_output({tag, "_rd_valid"}, 32'(rd_data_valid), 32'd0);
    check_output({tag, "_busy"}, 32'(busy), 32'd0);
    check_output({tag, "_cmd_err"}, 32'(cmd_err), 32'd0);
  endtask

  logic [31:0] d [4];
  logic [3:0]  m [4];
  logic [3:0]  m0 [4];

  initial begin
    m0 = '{4'h0, 4'h0, 4'h0, 4'h0};

    // Calibration delay, with a READ that must be ignored while uncalibrated.
    tick(2);
    check_reset_values("reset");
    rst_n = 1'b1;
    for (int j = 1; j <= 64; j++) begin
      tick();
      if (j == 10) begin cmd_en = 1'b1; cmd = 1'b0; addr = 21'h100; end
      if (j == 11) cmd_en = 1'b0;
      if (j == 63) check_output("calib_not_yet", 32'(init_calib), 32'd0);
      if (j == 64) check_output("calib_done", 32'(init_calib), 32'd1);
    end
    check_output("err_before_calib", 32'(cmd_err), 32'(ERRCHK));
    tick(10);

    rst_n = 1'b0;
    #1;
    check_reset_values("rereset");
    tick(2);
    rst_n = 1'b1;
    tick(64);
    check_output("calib_again", 32'(init_calib), 32'd1);

    // Full write and readback, then an aliased read of the same row.
    d = '{32'h11112222, 32'h33334444, 32'h55556666, 32'h77778888};
    apply_write(21'h100, d, m0);
    apply_read(21'h100, 1'b0);
    apply_read(21'h1FC100, 1'b0);

    // Byte masks over a known background.
    d = '{32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10};
    apply_write(21'h200, d, m0);
    d = '{32'hABCD0000, 32'hFFFFFFFF, 32'h12345678, 32'h00000000};
    m = '{4'b0111, 4'b1111, 4'b1111, 4'b1111};
    apply_write(21'h200, d, m);
    apply_read(21'h200, 1'b0);

    // Odd start address exercises the bank swap, including a partial mask.
    d = '{32'hA0A1A2A3, 32'hA4A5A6A7, 32'hA8A9AAAB, 32'hACADAEAF};
    apply_write(21'h300, d, m0);
    apply_write(21'h308, d, m0);
    d = '{32'hCAFEBABE, 32'hDEADBEEF, 32'h0BADF00D, 32'h600DD00D};
    m = '{4'b0000, 4'b1001, 4'b0000, 4'b0000};
    apply_write(21'h301, d, m);
    apply_read(21'h300, 1'b0);
    apply_read(21'h301, 1'b0);

    // Burst crossing the top of the address space wraps to 0.
    d = '{32'hB0B0B1B1, 32'hB2B2B3B3, 32'hB4B4B5B5, 32'hB6B6B7B7};
    apply_write(21'h000, d, m0);
    d = '{32'd1, 32'd2, 32'd3, 32'd4};
    apply_write(21'((1 << AW) - 2), d, m0);
    apply_read(21'h000, 1'b0);
    apply_read(21'h13FFE, 1'b0);

    // Command spacing: a poke while busy is dropped, the command at T+14 is taken.
    check_output("err_clean", 32'(cmd_err), 32'd0);
    apply_read(21'h100, 1'b1);
    apply_read(21'h200, 1'b0);

    // Reset during a write keeps only the beats already sampled.
    d = '{32'hC0C0C1C1, 32'hC2C2C3C3, 32'hC4C4C5C5, 32'hC6C6C7C7};
    apply_write(21'h400, d, m0);
    d = '{32'hD0D0D1D1, 32'hD2D2D3D3, 32'hD4D4D5D5, 32'hD6D6D7D7};
    cmd_en    = 1'b1;
    cmd       = 1'b1;
    addr      = 21'h400;
    wr_data   = d[0];
    data_mask = 4'h0;
    model_write(21'h400, 0, d[0], 4'h0);
    tick();
    cmd_en  = 1'b0;
    wr_data = d[1];
    model_write(21'h400, 1, d[1], 4'h0);
    tick();
    rst_n = 1'b0;
    #1;
    check_reset_values("midwrite_reset");
    wr_data   = d[2];
    data_mask = 4'hF;
    tick(2);
    rst_n = 1'b1;
    tick(64);
    check_output("calib_after_abort", 32'(init_calib), 32'd1);
    apply_read(21'h400, 1'b0);

    tick(5);
    check_output("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/psram_user_emu.md
# psram_user_emu

Synthesizable responder for the PSRAM controller user-side channel: accepts cmd/cmd_en/addr/wr_data/data_mask bursts exactly as the DCJ11 RAM front end issues them, and returns rd_data/rd_data_valid bursts from on-chip block RAM. It drops in place of the PSRAM controller channel 0 for boards without PSRAM, small-memory builds, and fast simulation. It also models calibration delay and command spacing, so front-end timing is exercised realistically.

## Interface
Parameters:
- AW, 14: stored halfword-address bits (2^AW halfwords); upper addr bits ignored (aliasing).
- BURST, 4: 32-bit beats per command.
- READ_LAT, 6: cycles from command accept to first read beat.
- TRC, 4: idle cycles after a burst's last beat before the next accept.
- INIT_CYCLES, 64: cycles after reset release before init_calib rises.

Ports:
- clk_out  in  1  user clock; all logic on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- init_calib  out  1  calibration done; commands ignored while 0.
- cmd  in  1  0 = READ, 1 = WRITE; sampled with cmd_en.
- cmd_en  in  1  command strobe, one cycle.
- addr  in  21  16-bit-halfword start address.
- wr_data  in  32  write beat; [31:16] → halfword at a, [15:0] → a+1.
- data_mask  in  4  per-byte mask, 1 = not written; bit3 = [31:24] … bit0 = [7:0].
- rd_data  out  32  read beat, same lane mapping as wr_data.
- rd_data_valid  out  1  high for each read beat.
- busy  out  1  high from accept through end of TRC gap.
- cmd_err  out  1  sticky protocol-error flag.

## Operation
- Storage: two halfword banks (even/odd address), each with two byte enables; beat k covers halfwords a+2k and a+2k+1 (mod 2^AW), always one per bank. Contents not cleared by reset.
- FSM states: INIT → IDLE → (RD_WAIT → RD_BEAT) or WR_BEAT → GAP → IDLE.
- INIT: counter runs INIT_CYCLES after rst_n rises; then init_calib = 1 until next reset.
- IDLE: cmd_en = 1 accepts; latch cmd and addr, and set busy.
- WRITE: beat 0 = wr_data/data_mask in the accept cycle; beats 1..BURST-1 in the following consecutive cycles. Each beat is written with its own mask; an all-ones mask writes nothing.
- READ: RD_WAIT counts down, then RD_BEAT outputs BURST consecutive beats.
- GAP: TRC cycles, then IDLE.
- Address arithmetic is modulo 2^AW; a burst crossing the top wraps to 0.
- rd_data holds the last beat between bursts.

## Timing
- Reset values: init_calib 0, rd_data 0, rd_data_valid 0, busy 0, cmd_err 0, FSM INIT.
- Accept at edge T: busy = 1 from T+1.
- Read beats: rd_data_valid = 1 in cycles T+READ_LAT … T+READ_LAT+BURST-1.
- Read data reflects all writes whose beats completed before T.
- Earliest next accept:
  - after read: T+READ_LAT+BURST+TRC (defaults: T+14).
  - after write: T+BURST+TRC (defaults: T+8).
- cmd_en while busy or init_calib = 0: ignored.
- cmd_en simultaneous with the last GAP cycle: ignored; the accept point is IDLE only.
- Reset mid-burst: abort immediately. Write beats already sampled stay in RAM; outputs return to reset values and INIT restarts.

## Configuration
- PSRAM_EMU_ERRCHK_EN defined: protocol checker sets cmd_err (sticky until reset) on cmd_en while busy, cmd_en before init_calib, or cmd_en held high two consecutive cycles. Offending commands are still dropped.
- Not defined: cmd_err tied 0; dropped commands are silent.

## Test plan
- Calibration: reset, then cmd_en READ at cycle 10 → no rd_data_valid. init_calib rises exactly 64 cycles after rst_n release.
- Write/readback: WRITE addr 0x100, beats 0x11112222, 0x33334444, 0x55556666, 0x77778888, mask 0000. Then READ 0x100 → 4 valid beats starting at T+6 with identical data; halfword 0x101 = 0x2222.
- Byte masks: WRITE addr 0x200, beat0 0xABCD0000 mask 0111, beats 1–3 mask 1111. READ → beat0 [31:16] = 0xAB?? with low byte unchanged from the previous contents; beats 1–3 unchanged.
- Wrap: WRITE at addr 2^AW-2 with beats 1..4 → READ addr 0 returns beats 2..4 in its first three beats; addr bits above AW alias.
- Spacing/error: READ at T, second cmd_en at T+5 → ignored, cmd_err = 1 with macro, 0 without. Command at T+14 is accepted.
- Reset mid-write: rst_n low after beat 1 → beats 0–1 persist in RAM, beats 2–3 do not; all outputs return to 0.
